pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Consumer side of the hazard/forwarding path in the 5-stage pipeline.
- Takes the hazard-detect stall request, the EXE-stage branch-taken indication and the MEM-stage data-memory handshake.
- Drives freeze, flush and bubble controls for PC, IF/ID, ID/EX and the back-end pipeline registers.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_WIDTH, 16, width of stall_cnt and flush_cnt.
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed per taken branch. Legal range 1..15.
- MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles after which mem_timeout sets. Must be ≥1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- hazard_detected  input  1  load-use/branch hazard request from hazard detection.
- branch_taken  input  1  branch resolved taken in EXE this cycle.
- mem_access  input  1  MEM stage issues a data-memory read or write this cycle.
- mem_ready  input  1  data memory completes the access this cycle.
- freeze_pc  output  1  hold the PC.
- freeze_if_id  output  1  hold the IF/ID register.
- flush_if_id  output  1  clear IF/ID to a NOP on the next edge.
- bubble_id_ex  output  1  clear ID/EX control bits, inserting a bubble.
- freeze_pipe  output  1  hold the ID/EX, EXE/MEM and MEM/WB registers.
- stall_cnt  output  CNT_WIDTH  cycles with freeze_pc=1, saturating.
- flush_cnt  output  CNT_WIDTH  cycles with flush_if_id=1, saturating.
- mem_timeout  output  1  sticky; set when a memory wait reaches MEM_TIMEOUT.

Behaviour:
- Clock and reset
  - One clock domain.
  - rst asynchronously sets: state=RUN, flush counter=0, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - All control outputs are forced to 0 while rst=1.
- Output timing
  - Control outputs are combinational from state and current inputs, so they take effect in the same cycle as the request (zero latency).
  - Counters and flags are registered.
- Definition: mem_stall = mem_access & ~mem_ready.
- Priority in every state: mem_stall > branch flush > hazard_detected.
- RUN state
  - If mem_stall: freeze_pc=1, freeze_if_id=1, freeze_pipe=1; next state MEM_WAIT; wait counter loads 1.
  - Else if branch_taken: flush_if_id=1, bubble_id_ex=1. Next state is FLUSH with flush counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, otherwise RUN. hazard_detected is ignored that cycle, because the flushed instruction is discarded.
  - Else if hazard_detected: freeze_pc=1, freeze_if_id=1, bubble_id_ex=1; stay in RUN. The request is re-evaluated each cycle, so an N-cycle request gives an N-cycle stall.
  - Else all controls are 0.
- MEM_WAIT state
  - While mem_ready=0: freeze_pc, freeze_if_id and freeze_pipe are all 1. branch_taken and hazard_detected are ignored.
  - Wait counter increments each cycle. When it equals MEM_TIMEOUT, mem_timeout is set and stays set until rst; the state remains MEM_WAIT.
  - When mem_ready=1: freezes drop that cycle (the pipeline advances); wait counter clears. The cycle is then evaluated with RUN rules minus the mem_stall branch. Next state is RUN, or FLUSH if a taken branch is accepted.
- FLUSH state
  - If no mem_stall: flush_if_id=1 and bubble_id_ex=1; flush counter decrements; return to RUN when it is 0 at the edge.
  - A new branch_taken while in FLUSH reloads the counter to FLUSH_CYCLES-1.
  - If mem_stall occurs in FLUSH: flush outputs are 0, all freezes are 1, the flush counter holds, and the state stays FLUSH until the memory completes.
- Counters
  - stall_cnt increments on every clock edge where freeze_pc=1.
  - flush_cnt increments on every clock edge where flush_if_id=1.
  - Both saturate at all-ones and never wrap.
- Invariants
  - flush_if_id and freeze_if_id are never 1 in the same cycle.
  - freeze_pipe=1 implies bubble_id_ex=0.
- Reset mid-operation (for example, inside MEM_WAIT or FLUSH) abandons the state immediately; outputs are 0 on the following cycle with no held requests.

Test Plan:
1. Reset, then hazard_detected=1 for 2 cycles with no other inputs → freeze_pc, freeze_if_id and bubble_id_ex are high for exactly 2 cycles; stall_cnt=2; flush_cnt=0.
2. FLUSH_CYCLES=1, branch_taken pulse with hazard_detected=1 in the same cycle → one cycle of flush_if_id=bubble_id_ex=1, freeze_pc=0; flush_cnt=1; state stays RUN.
3. FLUSH_CYCLES=3, branch_taken pulse → flush_if_id high for 3 consecutive cycles; a second branch_taken in cycle 2 extends the flush to cycle 4; flush_cnt=4.
4. mem_access=1, mem_ready=0 for 4 cycles then mem_ready=1 → freeze_pipe is high for 4 cycles and low in the mem_ready cycle; branch_taken asserted during the wait produces no flush; stall_cnt=4.
5. MEM_TIMEOUT=3, memory wait of 5 cycles → mem_timeout rises on the 3rd wait cycle, stays set after completion, and clears only on rst.
6. rst asserted in the 2nd cycle of a 3-cycle FLUSH and during a MEM_WAIT → outputs go to 0 immediately; counters read 0; the next hazard_detected is handled from RUN.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: consumer side of the hazard/forwarding path in the 5-stage pipeline.
// Latency: control outputs are combinational from state and inputs, so a request acts in the same cycle.
//          Performance counters and the timeout flag are registered.
// Backpressure: an outstanding data-memory access (mem_access & ~mem_ready) freezes the whole pipe and
//               overrides branch flushes, which in turn override hazard stalls.
//
// Ports:
//   clk, rst         pipeline clock (rising edge), asynchronous active-high reset
//   hazard_detected  load-use/branch hazard request -> stall PC and IF/ID, bubble ID/EX
//   branch_taken     EXE resolved a taken branch   -> flush IF/ID, bubble ID/EX
//   mem_access       MEM stage issues a data-memory access this cycle
//   mem_ready        data memory completes the access this cycle
//   freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_pipe   pipeline register controls
//   stall_cnt, flush_cnt   saturating counts of freeze_pc / flush_if_id cycles
//   mem_timeout      sticky flag, set when one memory wait lasts MEM_TIMEOUT cycles

module pipeline_stall_ctrl #(
  parameter int CNT_WIDTH    = 16,
  parameter int FLUSH_CYCLES = 1,    // 1..15
  parameter int MEM_TIMEOUT  = 255   // >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_access,
  input  logic                 mem_ready,
  output logic                 freeze_pc,
  output logic                 freeze_if_id,
  output logic                 flush_if_id,
  output logic                 bubble_id_ex,
  output logic                 freeze_pipe,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_timeout
);

  // ------------------------------------------------------------------
  // Local constants
  // ------------------------------------------------------------------
  localparam int             WAIT_W       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0]     FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  // With a single flush cycle the branch cycle itself is the whole flush,
  // so the FLUSH state is never entered.
  localparam bit             MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_e                state_q,     state_d;
  logic [3:0]            flush_ctr_q, flush_ctr_d;
  logic [WAIT_W-1:0]     wait_ctr_q,  wait_ctr_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
  logic                  timeout_q,   timeout_d;

  // Raw (ungated) control decisions from the next-state logic
  logic freeze_pc_c;
  logic freeze_if_id_c;
  logic flush_if_id_c;
  logic bubble_id_ex_c;
  logic freeze_pipe_c;

  logic mem_stall;
  assign mem_stall = mem_access & ~mem_ready;

  // ------------------------------------------------------------------
  // Next-state and control decode
  // ------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    flush_ctr_d    = flush_ctr_q;
    freeze_pc_c    = 1'b0;
    freeze_if_id_c = 1'b0;
    flush_if_id_c  = 1'b0;
    bubble_id_ex_c = 1'b0;
    freeze_pipe_c  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze_pc_c    = 1'b1;
          freeze_if_id_c = 1'b1;
          freeze_pipe_c  = 1'b1;
          state_d        = MEM_WAIT;
        end else if (branch_taken) begin
          // The instruction behind the branch is discarded, so a
          // simultaneous hazard request is irrelevant.
          flush_if_id_c  = 1'b1;
          bubble_id_ex_c = 1'b1;
          flush_ctr_d    = FLUSH_RELOAD;
          state_d        = MULTI_FLUSH ? FLUSH : RUN;
        end else if (hazard_detected) begin
          freeze_pc_c    = 1'b1;
          freeze_if_id_c = 1'b1;
          bubble_id_ex_c = 1'b1;
        end
      end

      MEM_WAIT: begin
        // The access is already outstanding; only completion matters here.
        if (!mem_ready) begin
          freeze_pc_c    = 1'b1;
          freeze_if_id_c = 1'b1;
          freeze_pipe_c  = 1'b1;
        end else begin
          // Completion cycle: the pipe advances and this cycle's branch or
          // hazard request is honoured exactly as in RUN.
          state_d = RUN;
          if (branch_taken) begin
            flush_if_id_c  = 1'b1;
            bubble_id_ex_c = 1'b1;
            flush_ctr_d    = FLUSH_RELOAD;
            state_d        = MULTI_FLUSH ? FLUSH : RUN;
          end else if (hazard_detected) begin
            freeze_pc_c    = 1'b1;
            freeze_if_id_c = 1'b1;
            bubble_id_ex_c = 1'b1;
          end
        end
      end

      FLUSH: begin
        if (mem_stall) begin
          // Memory wins; the remaining flush count is kept for later.
          freeze_pc_c    = 1'b1;
          freeze_if_id_c = 1'b1;
          freeze_pipe_c  = 1'b1;
        end else begin
          flush_if_id_c  = 1'b1;
          bubble_id_ex_c = 1'b1;
          if (branch_taken) begin
            flush_ctr_d = FLUSH_RELOAD;
          end else if (flush_ctr_q <= 4'd1) begin
            flush_ctr_d = 4'd0;
            state_d     = RUN;
          end else begin
            flush_ctr_d = flush_ctr_q - 4'd1;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Output gating: nothing is requested while reset is held
  // ------------------------------------------------------------------
  assign freeze_pc    = freeze_pc_c    & ~rst;
  assign freeze_if_id = freeze_if_id_c & ~rst;
  assign flush_if_id  = flush_if_id_c  & ~rst;
  assign bubble_id_ex = bubble_id_ex_c & ~rst;
  assign freeze_pipe  = freeze_pipe_c  & ~rst;

  // ------------------------------------------------------------------
  // Wait counter, timeout flag and performance counters
  // ------------------------------------------------------------------
  logic [WAIT_W-1:0] wait_inc;

  always_comb begin
    // freeze_pipe marks every cycle spent waiting on memory, whichever state
    // we are in; the counter is zero in any other cycle, so the first wait
    // cycle always lands on 1.
    wait_inc    = (wait_ctr_q == WAIT_MAX) ? wait_ctr_q : wait_ctr_q + 1'b1;
    wait_ctr_d  = freeze_pipe ? wait_inc : '0;
    timeout_d   = timeout_q | (freeze_pipe && (wait_inc == WAIT_MAX));

    stall_cnt_d = stall_cnt_q;
    if (freeze_pc && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    flush_cnt_d = flush_cnt_q;
    if (flush_if_id && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_ctr_q <= 4'd0;
      wait_ctr_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_ctr_q <= flush_ctr_d;
      wait_ctr_q  <= wait_ctr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed bench for pipeline_stall_ctrl.
// Two instances share inputs: u_a (CNT_WIDTH=3, FLUSH_CYCLES=1, MEM_TIMEOUT=3)
// and u_b (CNT_WIDTH=16, FLUSH_CYCLES=3, MEM_TIMEOUT=255).
// Control vectors are packed {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_pipe}.

module tb_pipeline_stall_ctrl;

  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_HAZ   = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_MEM   = 5'b11001;

  logic clk = 1'b0;
  logic rst;
  logic hazard_detected, branch_taken, mem_access, mem_ready;

  logic       fpc_a, fifid_a, flif_a, bub_a, fpipe_a, tmo_a;
  logic [2:0] scnt_a, fcnt_a;
  logic       fpc_b, fifid_b, flif_b, bub_b, fpipe_b, tmo_b;
  logic [15:0] scnt_b, fcnt_b;

  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {fpc_a, fifid_a, flif_a, bub_a, fpipe_a};
  assign ctl_b = {fpc_b, fifid_b, flif_b, bub_b, fpipe_b};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_WIDTH(3), .FLUSH_CYCLES(1), .MEM_TIMEOUT(3)) u_a (
    .clk(clk), .rst(rst),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .freeze_pc(fpc_a), .freeze_if_id(fifid_a), .flush_if_id(flif_a),
    .bubble_id_ex(bub_a), .freeze_pipe(fpipe_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a), .mem_timeout(tmo_a)
  );

  pipeline_stall_ctrl #(.CNT_WIDTH(16), .FLUSH_CYCLES(3), .MEM_TIMEOUT(255)) u_b (
    .clk(clk), .rst(rst),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .freeze_pc(fpc_b), .freeze_if_id(fifid_b), .flush_if_id(flif_b),
    .bubble_id_ex(bub_b), .freeze_pipe(fpipe_b),
    .stall_cnt(scnt_b), .flush_cnt(fcnt_b), .mem_timeout(tmo_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge, then let
  // combinational outputs settle before the caller checks them.
  task automatic drive(input logic r, input logic h, input logic b,
                       input logic ma, input logic mr);
    @(negedge clk);
    rst             = r;
    hazard_detected = h;
    branch_taken    = b;
    mem_access      = ma;
    mem_ready       = mr;
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b0;

    // Reset state, and controls forced low while rst is held
    drive(1, 1, 1, 1, 0);
    chk("rst_ctl_a", 16'(ctl_a), 16'(C_IDLE));
    chk("rst_ctl_b", 16'(ctl_b), 16'(C_IDLE));
    chk("rst_scnt_b", scnt_b, 16'd0);
    chk("rst_fcnt_b", fcnt_b, 16'd0);
    chk("rst_tmo_a", 16'(tmo_a), 16'd0);
    drive(0, 0, 0, 0, 0);
    chk("idle_ctl_b", 16'(ctl_b), 16'(C_IDLE));

    // 1: two-cycle hazard stall
    drive(0, 1, 0, 0, 0);
    chk("haz1_ctl_b", 16'(ctl_b), 16'(C_HAZ));
    drive(0, 1, 0, 0, 0);
    chk("haz2_ctl_b", 16'(ctl_b), 16'(C_HAZ));
    drive(0, 0, 0, 0, 0);
    chk("haz3_ctl_b", 16'(ctl_b), 16'(C_IDLE));
    chk("haz_scnt_b", scnt_b, 16'd2);
    chk("haz_scnt_a", 16'(scnt_a), 16'd2);
    chk("haz_fcnt_b", fcnt_b, 16'd0);

    // 2: branch with simultaneous hazard, single-cycle flush on u_a
    do_reset();
    drive(0, 1, 1, 0, 0);
    chk("br1_ctl_a", 16'(ctl_a), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("br1_next_ctl_a", 16'(ctl_a), 16'(C_IDLE));
    chk("br1_next_ctl_b", 16'(ctl_b), 16'(C_FLUSH));
    chk("br1_fcnt_a", 16'(fcnt_a), 16'd1);
    chk("br1_scnt_a", 16'(scnt_a), 16'd0);

    // 3a: three-cycle flush on u_b
    do_reset();
    drive(0, 0, 1, 0, 0);
    chk("fl3_c1", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("fl3_c2", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("fl3_c3", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("fl3_c4", 16'(ctl_b), 16'(C_IDLE));
    chk("fl3_fcnt_b", fcnt_b, 16'd3);

    // 3b: second branch in cycle 2 extends the flush to cycle 4
    do_reset();
    drive(0, 0, 1, 0, 0);
    chk("fl4_c1", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 1, 0, 0);
    chk("fl4_c2", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("fl4_c3", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("fl4_c4", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("fl4_c5", 16'(ctl_b), 16'(C_IDLE));
    chk("fl4_fcnt_b", fcnt_b, 16'd4);

    // 4: four-cycle memory wait, branch/hazard ignored while waiting
    do_reset();
    drive(0, 0, 0, 1, 0);
    chk("mw_c1", 16'(ctl_b), 16'(C_MEM));
    drive(0, 0, 1, 1, 0);
    chk("mw_c2_br", 16'(ctl_b), 16'(C_MEM));
    drive(0, 1, 0, 1, 0);
    chk("mw_c3_haz", 16'(ctl_b), 16'(C_MEM));
    drive(0, 0, 0, 1, 0);
    chk("mw_c4", 16'(ctl_b), 16'(C_MEM));
    drive(0, 0, 0, 1, 1);
    chk("mw_done", 16'(ctl_b), 16'(C_IDLE));
    drive(0, 0, 0, 0, 0);
    chk("mw_after", 16'(ctl_b), 16'(C_IDLE));
    chk("mw_scnt_b", scnt_b, 16'd4);
    chk("mw_fcnt_b", fcnt_b, 16'd0);
    chk("mw_tmo_b", 16'(tmo_b), 16'd0);

    // 4b: branch accepted in the completion cycle enters FLUSH on u_b only
    do_reset();
    drive(0, 0, 0, 1, 0);
    chk("mwbr_c1", 16'(ctl_b), 16'(C_MEM));
    drive(0, 0, 1, 1, 1);
    chk("mwbr_c2_b", 16'(ctl_b), 16'(C_FLUSH));
    chk("mwbr_c2_a", 16'(ctl_a), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("mwbr_c3_b", 16'(ctl_b), 16'(C_FLUSH));
    chk("mwbr_c3_a", 16'(ctl_a), 16'(C_IDLE));

    // 4c: memory stall inside FLUSH holds the remaining flush count
    do_reset();
    drive(0, 0, 1, 0, 0);
    chk("flmem_c1", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 1, 0);
    chk("flmem_c2_b", 16'(ctl_b), 16'(C_MEM));
    chk("flmem_c2_a", 16'(ctl_a), 16'(C_MEM));
    drive(0, 0, 0, 1, 1);
    chk("flmem_c3_b", 16'(ctl_b), 16'(C_FLUSH));
    chk("flmem_c3_a", 16'(ctl_a), 16'(C_IDLE));
    drive(0, 0, 0, 0, 0);
    chk("flmem_c4", 16'(ctl_b), 16'(C_FLUSH));
    drive(0, 0, 0, 0, 0);
    chk("flmem_c5", 16'(ctl_b), 16'(C_IDLE));
    chk("flmem_fcnt_b", fcnt_b, 16'd3);
    chk("flmem_scnt_b", scnt_b, 16'd1);

    // 5: MEM_TIMEOUT=3 on u_a with a five-cycle wait
    do_reset();
    drive(0, 0, 0, 1, 0);
    chk("tmo_c1", 16'(tmo_a), 16'd0);
    drive(0, 0, 0, 1, 0);
    chk("tmo_c2", 16'(tmo_a), 16'd0);
    drive(0, 0, 0, 1, 0);
    chk("tmo_c3", 16'(tmo_a), 16'd0);
    drive(0, 0, 0, 1, 0);
    chk("tmo_c4", 16'(tmo_a), 16'd1);
    chk("tmo_c4_ctl", 16'(ctl_a), 16'(C_MEM));
    drive(0, 0, 0, 1, 0);
    chk("tmo_c5", 16'(tmo_a), 16'd1);
    drive(0, 0, 0, 1, 1);
    chk("tmo_done_ctl", 16'(ctl_a), 16'(C_IDLE));
    drive(0, 0, 0, 0, 0);
    chk("tmo_sticky_a", 16'(tmo_a), 16'd1);
    chk("tmo_b_clear", 16'(tmo_b), 16'd0);
    chk("tmo_scnt_a", 16'(scnt_a), 16'd5);
    // Four more stall cycles: 3-bit counter saturates at 7, 16-bit reaches 9
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("sat_scnt_a", 16'(scnt_a), 16'd7);
    chk("sat_scnt_b", scnt_b, 16'd9);
    chk("tmo_still_a", 16'(tmo_a), 16'd1);
    drive(1, 0, 0, 0, 0);
    chk("tmo_rst_a", 16'(tmo_a), 16'd0);
    chk("sat_rst_scnt_a", 16'(scnt_a), 16'd0);
    drive(0, 0, 0, 0, 0);

    // 6a: reset in the 2nd cycle of a 3-cycle flush
    drive(0, 0, 1, 0, 0);
    chk("rfl_c1", 16'(ctl_b), 16'(C_FLUSH));
    drive(1, 0, 0, 0, 0);
    chk("rfl_c2_ctl", 16'(ctl_b), 16'(C_IDLE));
    chk("rfl_c2_fcnt", fcnt_b, 16'd0);
    drive(0, 0, 0, 0, 0);
    chk("rfl_c3_ctl", 16'(ctl_b), 16'(C_IDLE));
    drive(0, 1, 0, 0, 0);
    chk("rfl_c4_haz", 16'(ctl_b), 16'(C_HAZ));

    // 6b: reset during a memory wait
    do_reset();
    drive(0, 0, 0, 1, 0);
    chk("rmw_c1", 16'(ctl_b), 16'(C_MEM));
    drive(1, 0, 0, 1, 0);
    chk("rmw_c2_ctl", 16'(ctl_b), 16'(C_IDLE));
    chk("rmw_c2_scnt", scnt_b, 16'd0);
    drive(0, 1, 0, 0, 0);
    chk("rmw_c3_haz", 16'(ctl_b), 16'(C_HAZ));
    drive(0, 0, 0, 0, 0);
    chk("rmw_scnt_b", scnt_b, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
